// File: rtl/fetch_dispatch_fsm_pkg.sv
// Shared types and constants for the fetch/dispatch controller.
// State encoding, opcode map and memory timeout limit.
package fetch_dispatch_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_F_MAR     = 4'd1,
    S_F_REQ     = 4'd2,
    S_F_CAP     = 4'd3,
    S_F_IR      = 4'd4,
    S_DECODE    = 4'd5,
    S_DISPATCH  = 4'd6,
    S_WAIT_EXEC = 4'd7,
    S_HALT      = 4'd8,
    S_ERR       = 4'd9
  } state_e;

  typedef enum logic {
    CLS_ALU  = 1'b0,
    CLS_LDST = 1'b1
  } cls_e;

  localparam logic [3:0] OP_LOAD   = 4'd11;
  localparam logic [3:0] OP_STORE  = 4'd12;
  localparam logic [3:0] OP_ILL_LO = 4'd13;
  localparam logic [3:0] OP_ILL_HI = 4'd14;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  function automatic cls_e op_class(input logic [3:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? CLS_LDST : CLS_ALU;
  endfunction

endpackage

// File: rtl/fetch_dispatch_fsm_timeout_ctr.sv
// Memory-wait timeout counter for the fetch request phase.
// expired fires on the wait cycle whose increment would reach the limit.
module fetch_timeout_ctr
  import fetch_dispatch_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && cnt_q != TIMEOUT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign expired = enable && !clear
                   && (cnt_q == TIMEOUT_MAX - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// Instruction fetch / decode / dispatch controller (Moore FSM).
// Strobes are decoded from the registered state only.
module fetch_dispatch_fsm
  import fetch_dispatch_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mfc,
  input  logic [3:0]  opcode,
  input  logic        exec_done,
  output logic        pc_out_en,
  output logic        mar_load,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mdr_read_en,
  output logic        mdr_out_en,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        ldsr_start,
  output logic        alu_start,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic        bus_err_q, bus_err_d;
  logic        illegal_q, illegal_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  logic tmo_clear, tmo_en, tmo_expired;

  assign tmo_clear = (state_q == S_F_MAR);
  assign tmo_en    = (state_q == S_F_REQ) && !mfc;

  fetch_timeout_ctr u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    bus_err_d   = bus_err_q;
    illegal_d   = illegal_q;
    instr_cnt_d = instr_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_F_MAR;
      end
      S_F_MAR: state_d = S_F_REQ;
      S_F_REQ: begin
        if (mfc) begin
          state_d = S_F_CAP;
        end else if (tmo_expired) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
        end
      end
      S_F_CAP: state_d = S_F_IR;
      S_F_IR:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d     = S_HALT;
          instr_cnt_d = instr_cnt_q + 16'd1;
        end else if (opcode == OP_ILL_LO
                     || opcode == OP_ILL_HI) begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end else begin
          cls_d   = op_class(opcode);
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: state_d = S_WAIT_EXEC;
      S_WAIT_EXEC: begin
        // run is only honoured here, at the instruction boundary
        if (exec_done) begin
          instr_cnt_d = instr_cnt_q + 16'd1;
          state_d     = run ? S_F_MAR : S_IDLE;
        end
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out_en   = 1'b0;
    mar_load    = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    mdr_read_en = 1'b0;
    mdr_out_en  = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    ldsr_start  = 1'b0;
    alu_start   = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_F_MAR: begin
        pc_out_en = 1'b1;
        mar_load  = 1'b1;
      end
      S_F_REQ: begin
        mem_en = 1'b1;
        mem_rw = 1'b1;
      end
      S_F_CAP: mdr_read_en = 1'b1;
      S_F_IR: begin
        mdr_out_en = 1'b1;
        ir_load    = 1'b1;
      end
      S_DECODE: pc_inc = 1'b1;
      S_DISPATCH: begin
        ldsr_start = (cls_q == CLS_LDST);
        alu_start  = (cls_q == CLS_ALU);
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_err   = bus_err_q;
  assign illegal   = illegal_q;
  assign instr_cnt = instr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cls_q       <= CLS_ALU;
      bus_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      bus_err_q   <= bus_err_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule
